pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the IF, IF/ID and ID/EX stages of the 5-stage RV32I core.
//  - Generates PC enable, IF/ID hold/flush and ID/EX hold/flush.
//  - Sources: EX-resolved redirects, load-use hazards, multi-cycle EX busy, imem wait.
//  - Sits beside the IF/ID pipeline register and the PC; owns no datapath.
// PARAMETERS
//  REDIR_BUBBLES  2   extra IF/ID bubble cycles after a redirect (0..15)
//  CNT_W          32  width of perf counters (STALL_COUNTER_EN only)
// PORTS
//  clk            in   1      core clock
//  rst            in   1      reset, asynchronous, active-low
//  id_rs1,id_rs2  in   5      source regs of instruction in ID
//  id_use_rs1/2   in   1      ID instruction actually reads rs1/rs2
//  ex_mem_read    in   1      instruction in EX is a load
//  ex_rd          in   5      destination reg of instruction in EX
//  ex_redirect    in   1      branch taken / jump resolved in EX this cycle
//  ex_busy        in   1      multi-cycle EX unit not done
//  imem_ready     in   1      fetch data valid this cycle
//  pc_en          out  1      PC register load enable
//  if_id_en       out  1      IF/ID load enable (0 = hold)
//  if_id_flush    out  1      IF/ID loads NOP 32'h0000_0013, pc 0
//  id_ex_en       out  1      ID/EX load enable (0 = hold)
//  id_ex_flush    out  1      ID/EX loads bubble
//  state          out  2      FSM state (RUN=0, REDIR=1, IWAIT=2)
// BEHAVIOUR
//  - Reset (rst=0, async): state=RUN, bubble cnt=0, counters=0.
//    Outputs forced while rst=0: pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=1, id_ex_flush=1.
//  - Outputs are combinational from state+inputs; next state registered on clk rise.
//  - load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - Priority per cycle: ex_redirect > ex_busy > load_use > !imem_ready.
//  - RUN:
//    - redirect: pc_en=1, if_id_flush=1, id_ex_flush=1.
//      -> REDIR with cnt=REDIR_BUBBLES if REDIR_BUBBLES>0, else stay RUN.
//    - ex_busy: pc_en=0, if_id_en=0, id_ex_en=0, no flush; stay RUN.
//    - load_use: pc_en=0, if_id_en=0, id_ex_flush=1 (exactly one bubble; load leaves EX next cycle).
//    - !imem_ready: pc_en=0, if_id_flush=1; -> IWAIT.
//    - otherwise: all enables 1, flushes 0.
//  - REDIR: if_id_flush=1, pc_en=imem_ready, id_ex_en=1.
//    - cnt decrements when imem_ready; cnt==1 & imem_ready -> RUN.
//    - ex_redirect here reloads cnt with same RUN-redirect outputs.
//    - ex_busy/load_use impossible (EX holds bubbles); ignored.
//  - IWAIT: pc_en=0, if_id_flush=1 each cycle; older instrs drain normally.
//    - imem_ready=1 -> pc_en=1, if_id_en=1, flush=0, -> RUN same cycle.
//    - ex_redirect overrides -> REDIR.
//    - ex_busy: hold ID/EX, keep IF/ID bubble.
//  - Never assert en=1 and flush=1 on the same stage; flush wins (en forced 0).
//  - rst falling mid-REDIR/IWAIT: immediate return to RUN, cnt=0.
// CONFIGURATION
//  STALL_COUNTER_EN defined:
//    - adds outputs stall_cycles, flush_cycles [CNT_W-1:0].
//    - stall_cycles +1 per cycle with pc_en=0 and no redirect.
//    - flush_cycles +1 per cycle with if_id_flush=1 (rst=1 only).
//    - both saturate at all-ones; clear on reset.
//  Undefined: ports and logic absent; behaviour otherwise identical.
// TESTING
//  1 Reset: hold rst=0 3 cycles mid-IWAIT -> state=0, pc_en=0, both flushes 1; release -> RUN outputs.
//  2 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 ->
//    exactly 1 cycle pc_en=0, if_id_en=0, id_ex_flush=1; ex_rd=0 -> no stall.
//  3 Redirect, REDIR_BUBBLES=2, imem_ready=1 -> cycle0 both flushes;
//    cycles1-2 if_id_flush=1; cycle3 RUN.
//  4 Redirect + load_use + ex_busy same cycle -> redirect outputs only, state->REDIR.
//  5 imem_ready low 4 cycles from RUN -> 4 bubbles, pc_en=0, state=IWAIT;
//    ready -> RUN with pc_en=1 same cycle.
//  6 STALL_COUNTER_EN, CNT_W=4: 20 stall cycles -> stall_cycles=4'hF (saturated).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF, IF/ID and ID/EX stages of the 5-stage RV32I core.
// Optional perf counters (stall_cycles, flush_cycles) are built when STALL_COUNTER_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REDIR_BUBBLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_redirect,
  input  logic       ex_busy,
  input  logic       imem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic [1:0] state
`ifdef STALL_COUNTER_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    IWAIT = 2'd2
  } state_t;

  if (REDIR_BUBBLES < 0 || REDIR_BUBBLES > 15) begin : g_bad_bubbles
    $error("REDIR_BUBBLES must be in 0..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en_c       = 1'b1;
    if_id_en_c    = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_en_c    = 1'b1;
    id_ex_flush_c = 1'b0;

    if (ex_redirect) begin
      // A redirect from any state squashes both younger stages and restarts the bubble count.
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      if (REDIR_BUBBLES > 0) begin
        state_d = REDIR;
        cnt_d   = 4'(REDIR_BUBBLES);
      end else begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (ex_busy) begin
            pc_en_c    = 1'b0;
            if_id_en_c = 1'b0;
            id_ex_en_c = 1'b0;
          end else if (load_use) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
          end else if (!imem_ready) begin
            pc_en_c       = 1'b0;
            if_id_flush_c = 1'b1;
            state_d       = IWAIT;
          end
        end
        REDIR: begin
          // EX only sees bubbles here, so busy and load-use cannot occur.
          if_id_flush_c = 1'b1;
          pc_en_c       = imem_ready;
          if (imem_ready) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RUN;
          end
        end
        IWAIT: begin
          if (ex_busy) begin
            pc_en_c       = 1'b0;
            if_id_flush_c = 1'b1;
            id_ex_en_c    = 1'b0;
          end else if (!imem_ready) begin
            pc_en_c       = 1'b0;
            if_id_flush_c = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush overrides enable on a stage; reset forces every stage to flush and hold.
  assign pc_en       = rst && pc_en_c;
  assign if_id_flush = !rst || if_id_flush_c;
  assign id_ex_flush = !rst || id_ex_flush_c;
  assign if_id_en    = rst && if_id_en_c && !if_id_flush_c;
  assign id_ex_en    = rst && id_ex_en_c && !id_ex_flush_c;
  assign state       = state_q;

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (!pc_en && !ex_redirect && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (if_id_flush && (flush_cycles_q != {CNT_W{1'b1}}))
      flush_cycles_d = flush_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + randomized bench for pipeline_hazard_ctrl against a rule-level reference model.
// Build with STALL_COUNTER_EN defined to also exercise the perf counters (CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int BUB   = 2;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;
  localparam int M_RUN = 0;
  localparam int M_RED = 1;
  localparam int M_IW  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_busy, imem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic [1:0] state;
`ifdef STALL_COUNTER_EN
  logic [CW-1:0] stall_cycles, flush_cycles;
`endif

  pipeline_hazard_ctrl #(.REDIR_BUBBLES(BUB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .ex_busy(ex_busy), .imem_ready(imem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .state(state)
`ifdef STALL_COUNTER_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int mode     = M_RUN;
  int bub      = 0;
  int stall_m  = 0;
  int flush_m  = 0;
  int txn      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s txn=%0d observed=%0h expected=%0h", tag, txn, obs, expv);
    end
  endtask

  // One clock of stimulus: drive, check combinational outputs, then advance model on the edge.
  task automatic step(input logic r, input logic red, input logic busy, input logic ready,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2);
    logic lu;
    logic e_pc, e_ife, e_iff, e_ide, e_idf;
    int   nmode, nbub;
    rst = r; ex_redirect = red; ex_busy = busy; imem_ready = ready; ex_mem_read = mr;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    #1;
    lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!r) begin
      mode = M_RUN; bub = 0; stall_m = 0; flush_m = 0;
    end
    nmode = mode; nbub = bub;
    // Encoded as {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush}
    {e_pc, e_ife, e_iff, e_ide, e_idf} = 5'b11010;
    if (!r)                        {e_pc, e_ife, e_iff, e_ide, e_idf} = 5'b00101;
    else if (red) begin
      {e_pc, e_ife, e_iff, e_ide, e_idf} = 5'b10101;
      nmode = (BUB > 0) ? M_RED : M_RUN; nbub = BUB;
    end else if (mode == M_RED) begin
      {e_pc, e_ife, e_iff, e_ide, e_idf} = {ready, 4'b0110};
      if (ready) begin
        nbub = bub - 1;
        if (nbub == 0) nmode = M_RUN;
      end
    end else if (mode == M_IW) begin
      if (busy)        {e_pc, e_ife, e_iff, e_ide, e_idf} = 5'b00100;
      else if (!ready) {e_pc, e_ife, e_iff, e_ide, e_idf} = 5'b00110;
      else nmode = M_RUN;
    end else begin
      if (busy)        {e_pc, e_ife, e_iff, e_ide, e_idf} = 5'b00000;
      else if (lu)     {e_pc, e_ife, e_iff, e_ide, e_idf} = 5'b00001;
      else if (!ready) begin
        {e_pc, e_ife, e_iff, e_ide, e_idf} = 5'b00110;
        nmode = M_IW;
      end
    end
    chk("ctrl_outs", {27'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush},
        {27'd0, e_pc, e_ife, e_iff, e_ide, e_idf});
    chk("state", {30'd0, state}, mode);
`ifdef STALL_COUNTER_EN
    chk("stall_cycles", {28'd0, stall_cycles}, stall_m);
    chk("flush_cycles", {28'd0, flush_cycles}, flush_m);
`endif
    $display("txn %0d rst=%b red=%b busy=%b rdy=%b lu=%b -> pc=%b ife=%b iff=%b ide=%b idf=%b st=%0d",
             txn, r, red, busy, ready, lu, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, state);
    txn++;
    @(posedge clk);
    if (r) begin
      mode = nmode; bub = nbub;
      if (!e_pc && !red && stall_m < SAT) stall_m++;
      if (e_iff && flush_m < SAT) flush_m++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ready);
    step(1, 0, 0, ready, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    // Reset asserted from time zero
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);

`ifdef STALL_COUNTER_EN
    for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("stall_saturated", {28'd0, stall_cycles}, 32'hF);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
`endif

    // Load-use on rs2, then load has left EX, then ex_rd = x0 never stalls
    step(1, 0, 0, 1, 1, 5'd5, 5'd1, 5'd5, 0, 1);
    step(1, 0, 0, 1, 0, 5'd5, 5'd1, 5'd5, 0, 1);
    step(1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    step(1, 0, 0, 1, 1, 5'd7, 5'd7, 5'd2, 1, 0);
    idle(1);

    // Redirect with two bubbles
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1); idle(1); idle(1);

    // Redirect beats busy and load-use in the same cycle
    step(1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1);
    idle(0); idle(1); idle(1); idle(1);

    // Fetch stall for four cycles, then ready
    for (int i = 0; i < 4; i++) idle(0);
    idle(1);

    // Busy while in IWAIT, then redirect out of IWAIT
    idle(0);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1); idle(1); idle(1);

    // Reset asserted mid-IWAIT for three cycles
    idle(0); idle(0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Randomized traffic, small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
